multi_ch_accum: RTL and testbench

- Parametrised successor of the single-channel frame accumulator under TOP.
- Sums NCH parallel channels of BITS-wide samples over a frame of up to CGES beats.
- Adds a valid/ready input stream, early frame termination via fin, signed/unsigned mode, and a held result with an output handshake.
- Sits between the sample front-end and the result readout logic.

---
 rtl/multi_ch_accum_pkg.sv | 30 +++
 rtl/multi_ch_accum_lane.sv | 78 +++++++
 rtl/multi_ch_accum.sv | 112 +++++++++++
 tb/tb_multi_ch_accum.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_ch_accum_pkg.sv
// multi_ch_accum shared types and helpers.
// FSM state encoding, result width and sample extension.
package multi_ch_accum_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_e;

  localparam int unsigned XW = 128;

  function automatic int rw_f(int bits, int cges);
    return $clog2(cges) + bits;
  endfunction

  function automatic logic [XW-1:0] ext_f(
    logic [XW-1:0] x,
    int            bits,
    bit            sgn
  );
    logic [XW-1:0] m;
    m = {XW{1'b1}} << bits;
    ext_f = x & ~m;
    if (sgn && x[bits-1]) begin
      ext_f = ext_f | m;
    end
  endfunction

endpackage

// File: rtl/multi_ch_accum_lane.sv
// One channel accumulator with clear and enable.
// MULTI_CH_ACCUM_PEAK_EN adds a running maximum register.
module accum_lane
  import multi_ch_accum_pkg::*;
#(
  parameter int BITS   = 32,
  parameter int RW     = 38,
  parameter int SIGNED = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clr,
  input  logic            en,
  input  logic [BITS-1:0] din,
  output logic [RW-1:0]   acc
`ifdef MULTI_CH_ACCUM_PEAK_EN
  ,
  output logic [BITS-1:0] peak
`endif
);

  logic [RW-1:0] acc_q, acc_d;
  logic [RW-1:0] x_ext;

  // Extend the sample and form the next running sum.
  always_comb begin
    x_ext = RW'(ext_f(XW'(din), BITS, SIGNED != 0));
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + x_ext;
    end
  end

  // Running sum register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

`ifdef MULTI_CH_ACCUM_PEAK_EN
  localparam logic [BITS-1:0] PK_MIN =
    (SIGNED != 0) ? {1'b1, {(BITS-1){1'b0}}} : '0;

  logic [BITS-1:0] pk_q, pk_d;
  logic            gt;

  // Keep the largest sample, compared in the lane's signedness.
  always_comb begin
    gt = (SIGNED != 0) ? ($signed(din) > $signed(pk_q))
                       : (din > pk_q);
    pk_d = pk_q;
    if (clr) begin
      pk_d = PK_MIN;
    end else if (en && gt) begin
      pk_d = din;
    end
  end

  // Peak register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pk_q <= '0;
    end else begin
      pk_q <= pk_d;
    end
  end

  assign peak = pk_q;
`endif

endmodule

// File: rtl/multi_ch_accum.sv
// NCH-channel frame accumulator with in/out handshakes.
// MULTI_CH_ACCUM_PEAK_EN adds a per-channel peak output.
module multi_ch_accum
  import multi_ch_accum_pkg::*;
#(
  parameter  int BITS   = 32,
  parameter  int CGES   = 49,
  parameter  int NCH    = 4,
  parameter  int SIGNED = 0,
  localparam int RW     = rw_f(BITS, CGES),
  localparam int BW     = $clog2(CGES + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              fin,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NCH*BITS-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NCH*RW-1:0] result,
  output logic [BW-1:0]     beats,
  output logic              busy
`ifdef MULTI_CH_ACCUM_PEAK_EN
  ,
  output logic [NCH*BITS-1:0] peak
`endif
);

  localparam logic [BW-1:0] LAST = BW'(CGES - 1);

  state_e        state_q, state_d;
  logic [BW-1:0] beats_q, beats_d;
  logic          ov_q;
  logic          busy_q;
  logic          clr;
  logic          accept;

  assign in_ready = (state_q == S_ACCUM) & ~fin;
  assign accept   = in_valid & in_ready;
  assign clr      = (state_q == S_IDLE) & start;

  // Next state and beat count.
  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          beats_d = '0;
        end
      end
      S_ACCUM: begin
        if (fin) begin
          state_d = S_DONE;
        end else if (accept) begin
          beats_d = beats_q + 1'b1;
          if (beats_q == LAST) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and registered status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      beats_q <= '0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      ov_q    <= (state_d == S_DONE);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign out_valid = ov_q;
  assign busy      = busy_q;
  assign beats     = beats_q;

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    accum_lane #(
      .BITS   (BITS),
      .RW     (RW),
      .SIGNED (SIGNED)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clr),
      .en      (accept),
      .din     (in_data[c*BITS +: BITS]),
      .acc     (result[c*RW +: RW])
`ifdef MULTI_CH_ACCUM_PEAK_EN
      ,
      .peak    (peak[c*BITS +: BITS])
`endif
    );
  end

endmodule

// File: tb/tb_multi_ch_accum.sv
// Bench for multi_ch_accum: unsigned and signed instances
// on shared stimulus, checked against a frame-level model.
module tb_multi_ch_accum;

  localparam int BITS = 32;
  localparam int CGES = 49;
  localparam int NCH  = 4;
  localparam int RW   = 38;
  localparam int BW   = 6;

  logic clk = 1'b0;
  logic reset_n;
  logic start, fin, in_valid, out_ready;
  logic [NCH*BITS-1:0] in_data;

  logic [NCH*RW-1:0] res_u, res_s;
  logic [BW-1:0]     bt_u, bt_s;
  logic ov_u, ov_s, rdy_u, rdy_s, busy_u, busy_s;
`ifdef MULTI_CH_ACCUM_PEAK_EN
  logic [NCH*BITS-1:0] pk_u, pk_s;
`endif

  always #5 clk = ~clk;

  multi_ch_accum #(
    .BITS(BITS), .CGES(CGES), .NCH(NCH), .SIGNED(0)
  ) u_u (
    .clk(clk), .reset_n(reset_n), .start(start), .fin(fin),
    .in_valid(in_valid), .in_ready(rdy_u), .in_data(in_data),
    .out_valid(ov_u), .out_ready(out_ready), .result(res_u),
    .beats(bt_u), .busy(busy_u)
`ifdef MULTI_CH_ACCUM_PEAK_EN
    , .peak(pk_u)
`endif
  );

  multi_ch_accum #(
    .BITS(BITS), .CGES(CGES), .NCH(NCH), .SIGNED(1)
  ) u_s (
    .clk(clk), .reset_n(reset_n), .start(start), .fin(fin),
    .in_valid(in_valid), .in_ready(rdy_s), .in_data(in_data),
    .out_valid(ov_s), .out_ready(out_ready), .result(res_s),
    .beats(bt_s), .busy(busy_s)
`ifdef MULTI_CH_ACCUM_PEAK_EN
    , .peak(pk_s)
`endif
  );

  int nchk = 0;
  int nerr = 0;

  // Model: 0 idle, 1 accumulating, 2 holding result.
  int          m_st;
  int          m_beats;
  longint      m_acc [2][NCH];
  longint      m_pk  [2][NCH];
  logic [31:0] d [NCH];

  function automatic longint ext(logic [31:0] x, int s);
    if (s != 0) return longint'($signed(x));
    return longint'({32'b0, x});
  endfunction

  function automatic logic [63:0] trunc(longint v);
    logic [63:0] t;
    t = v;
    return t & ((64'd1 << RW) - 64'd1);
  endfunction

  task automatic check(string tag, logic [63:0] obs,
                       logic [63:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_out();
    check("ov_u", 64'(ov_u), 64'(m_st == 2));
    check("ov_s", 64'(ov_s), 64'(m_st == 2));
    check("busy_u", 64'(busy_u), 64'(m_st != 0));
    check("busy_s", 64'(busy_s), 64'(m_st != 0));
    check("beats_u", 64'(bt_u), 64'(m_beats));
    check("beats_s", 64'(bt_s), 64'(m_beats));
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("res_u[%0d]", c),
            64'(res_u[c*RW +: RW]), trunc(m_acc[0][c]));
      check($sformatf("res_s[%0d]", c),
            64'(res_s[c*RW +: RW]), trunc(m_acc[1][c]));
`ifdef MULTI_CH_ACCUM_PEAK_EN
      check($sformatf("pk_u[%0d]", c),
            64'(pk_u[c*BITS +: BITS]),
            64'(m_pk[0][c]) & 64'hFFFF_FFFF);
      check($sformatf("pk_s[%0d]", c),
            64'(pk_s[c*BITS +: BITS]),
            64'(m_pk[1][c]) & 64'hFFFF_FFFF);
`endif
    end
  endtask

  task automatic model_clear();
    m_st    = 0;
    m_beats = 0;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NCH; c++) begin
        m_acc[k][c] = 0;
        m_pk[k][c]  = 0;
      end
  endtask

  task automatic model_edge();
    longint v;
    case (m_st)
      0: if (start) begin
        m_st    = 1;
        m_beats = 0;
        for (int c = 0; c < NCH; c++) begin
          m_acc[0][c] = 0;
          m_acc[1][c] = 0;
          m_pk[0][c]  = 0;
          m_pk[1][c]  = -(64'sd1 <<< 31);
        end
      end
      1: if (fin) begin
        m_st = 2;
      end else if (in_valid) begin
        m_beats++;
        for (int k = 0; k < 2; k++)
          for (int c = 0; c < NCH; c++) begin
            v = ext(d[c], k);
            m_acc[k][c] += v;
            if (v > m_pk[k][c]) m_pk[k][c] = v;
          end
        if (m_beats == CGES) m_st = 2;
      end
      default: if (out_ready) m_st = 0;
    endcase
  endtask

  task automatic tick();
    for (int c = 0; c < NCH; c++)
      in_data[c*BITS +: BITS] = d[c];
    #1;
    check("rdy_u", 64'(rdy_u), 64'(m_st == 1 && !fin));
    check("rdy_s", 64'(rdy_s), 64'(m_st == 1 && !fin));
    @(posedge clk);
    model_edge();
    #1;
    check_out();
  endtask

  task automatic idle_in();
    start = 0; fin = 0; in_valid = 0; out_ready = 0;
  endtask

  task automatic set_all(logic [31:0] v);
    for (int c = 0; c < NCH; c++) d[c] = v;
  endtask

  task automatic set_rand();
    for (int c = 0; c < NCH; c++) d[c] = $urandom;
  endtask

  task automatic do_reset();
    reset_n = 0;
    #1;
    model_clear();
    check("rst_rdy_u", 64'(rdy_u), 64'd0);
    check_out();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    tick();
  endtask

  task automatic handshake();
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset_n = 0;
    idle_in();
    set_all(32'd0);
    in_data = '0;
    model_clear();
    #3;
    check_out();
    @(negedge clk);
    reset_n = 1;
    tick();

    // Full frame with the directed pattern.
    start = 1; tick(); start = 0;
    in_valid = 1;
    for (int i = 0; i < CGES; i++) begin
      d[0] = 32'd1; d[1] = 32'hFFFF_FFFF;
      d[2] = 32'd0; d[3] = 32'(i);
      tick();
    end
    in_valid = 0;
    check("full_ov", 64'(ov_u), 64'd1);
    check("full_ch0", 64'(res_u[0*RW +: RW]), 64'd49);
    check("full_ch1", 64'(res_u[1*RW +: RW]),
          64'h30_FFFF_FFCF);
    check("full_ch3", 64'(res_u[3*RW +: RW]), 64'd1176);
    check("full_beats", 64'(bt_u), 64'd49);
    handshake();

    // fin and in_valid in IDLE are ignored.
    fin = 1; in_valid = 1; out_ready = 1;
    tick(); tick();
    idle_in();

    // Same frame with gaps, start noise and backpressure.
    start = 1; tick(); start = 0;
    cyc = 0;
    while (m_st == 1 && cyc < 1000) begin
      in_valid = ($urandom_range(0, 2) != 0);
      start    = ($urandom_range(0, 3) == 0);
      d[0] = 32'd1; d[1] = 32'hFFFF_FFFF;
      d[2] = 32'd0; d[3] = 32'(m_beats);
      tick();
      cyc++;
    end
    idle_in();
    check("bp_done", 64'(ov_u), 64'd1);
    check("bp_ch1", 64'(res_u[1*RW +: RW]), 64'h30_FFFF_FFCF);
    check("bp_ch3", 64'(res_u[3*RW +: RW]), 64'd1176);
    start = 1; fin = 1; in_valid = 1;
    repeat (5) tick();
    idle_in();
    handshake();
    tick();

    // Early fin after 10 beats; concurrent beat dropped.
    start = 1; tick(); start = 0;
    set_all(32'd3);
    in_valid = 1;
    repeat (10) tick();
    fin = 1; tick();
    idle_in();
    check("fin_ch0", 64'(res_u[0*RW +: RW]), 64'd30);
    check("fin_beats", 64'(bt_u), 64'd10);
    handshake();

    // fin with no beats.
    start = 1; tick(); start = 0;
    fin = 1; tick(); fin = 0;
    check("fin0_ov", 64'(ov_u), 64'd1);
    check("fin0_res", 64'(res_u[2*RW +: RW]), 64'd0);
    check("fin0_beats", 64'(bt_u), 64'd0);
    handshake();

    // Most-negative samples for a full frame.
    start = 1; tick(); start = 0;
    set_all(32'h8000_0000);
    in_valid = 1;
    repeat (CGES) tick();
    in_valid = 0;
    check("sgn_ch0", 64'(res_s[0*RW +: RW]), 64'h27_8000_0000);
    check("uns_ch0", 64'(res_u[0*RW +: RW]), 64'h18_8000_0000);
    check("sgn_beats", 64'(bt_s), 64'd49);
    handshake();

    // Reset in the middle of a frame.
    start = 1; tick(); start = 0;
    in_valid = 1;
    repeat (20) begin set_rand(); tick(); end
    idle_in();
    do_reset();
    start = 1; tick(); start = 0;
    set_all(32'd7);
    in_valid = 1;
    repeat (5) tick();
    in_valid = 0;
    fin = 1; tick(); fin = 0;
    check("rst_ch2", 64'(res_u[2*RW +: RW]), 64'd35);
    check("rst_beats", 64'(bt_u), 64'd5);
    handshake();

`ifdef MULTI_CH_ACCUM_PEAK_EN
    start = 1; tick(); start = 0;
    in_valid = 1;
    set_all(32'd5); tick();
    set_all(32'd9); tick();
    set_all(32'd2); tick();
    in_valid = 0;
    fin = 1; tick(); fin = 0;
    check("peak_ch0", 64'(pk_u[0 +: BITS]), 64'd9);
    handshake();
`endif

    // Random frames.
    for (int f = 0; f < 8; f++) begin
      start = 1; tick(); start = 0;
      cyc = 0;
      while (m_st == 1 && cyc < 200) begin
        set_rand();
        in_valid = ($urandom_range(0, 3) != 0);
        fin      = ($urandom_range(0, 40) == 0);
        start    = ($urandom_range(0, 5) == 0);
        tick();
        cyc++;
      end
      idle_in();
      if (m_st == 1) begin fin = 1; tick(); fin = 0; end
      repeat ($urandom_range(0, 3)) tick();
      handshake();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
